muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide. Multiplies use 32-cycle radix-2
//            shift-add and divides use 32-cycle restoring division, both on
//            operand magnitudes. Define MULDIV_DIV_EN to build the divider.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        finish_flag,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic [2:0]  r_f3;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic        r_neg_q;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_is_div;
    logic        w_a_sgn;
    logic        w_b_sgn;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_fast;
    logic [31:0] w_fast_res;
    logic [63:0] w_mul_acc;
    logic [63:0] w_step;
    logic [63:0] w_prod;
    logic [31:0] w_final;

    assign w_accept = (r_state == S_IDLE) && start && !finish_flag;
    assign w_is_div = funct3[2];
    // Signed operands: a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
    assign w_a_sgn  = op_a[31] & ((funct3 == 3'b001) || (funct3 == 3'b010) ||
                                  (funct3 == 3'b100) || (funct3 == 3'b110));
    assign w_b_sgn  = op_b[31] & ((funct3 == 3'b001) || (funct3 == 3'b100) ||
                                  (funct3 == 3'b110));
    assign w_a_mag  = w_a_sgn ? (32'd0 - op_a) : op_a;
    assign w_b_mag  = w_b_sgn ? (32'd0 - op_b) : op_b;

    assign w_mul_acc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_prod    = r_neg_q ? (64'd0 - w_step) : w_step;

`ifdef MULDIV_DIV_EN
    logic        r_neg_r;
    logic        w_ovf;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [63:0] w_div_acc;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_ovf  = !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign w_fast = w_is_div && ((op_b == 32'd0) || w_ovf);

    always_comb begin
        w_fast_res = 32'd0;
        if (op_b == 32'd0)
            w_fast_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
        else if (w_ovf)
            w_fast_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // Remainder lives in acc[63:32], dividend/quotient shifts through acc[31:0].
    assign w_rem_sh  = {r_acc[63:32], r_acc[31]};
    assign w_diff    = w_rem_sh - {1'b0, r_mcand[31:0]};
    assign w_div_acc = w_diff[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                                  : {w_diff[31:0],   r_acc[30:0], 1'b1};
    assign w_step    = r_f3[2] ? w_div_acc : w_mul_acc;
    assign w_quo     = r_neg_q ? (32'd0 - w_step[31:0])  : w_step[31:0];
    assign w_rem     = r_neg_r ? (32'd0 - w_step[63:32]) : w_step[63:32];

    always_comb begin
        if (r_f3[2])
            w_final = r_f3[1] ? w_rem : w_quo;
        else
            w_final = (r_f3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_neg_r <= 1'b0;
        else if (w_accept)
            r_neg_r <= w_a_sgn;
    end
`else
    // Without the divider every divide opcode completes immediately with zero.
    assign w_fast     = w_is_div;
    assign w_fast_res = 32'd0;
    assign w_step     = w_mul_acc;
    assign w_final    = r_f3[2] ? 32'd0 :
                        ((r_f3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32]);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_fast ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == 5'd31) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= 5'd0;
            r_f3     <= 3'd0;
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_neg_q  <= 1'b0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= 5'd0;
                        r_f3    <= funct3;
                        r_neg_q <= w_a_sgn ^ w_b_sgn;
`ifdef MULDIV_DIV_EN
                        if (w_is_div) begin
                            r_acc    <= {32'd0, w_a_mag};
                            r_mcand  <= {32'd0, w_b_mag};
                            r_mplier <= 32'd0;
                        end else
`endif
                        begin
                            r_acc    <= 64'd0;
                            r_mcand  <= {32'd0, w_a_mag};
                            r_mplier <= w_b_mag;
                        end
                        if (w_fast)
                            r_result <= w_fast_res;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_step;
                    r_mcand  <= r_f3[2] ? r_mcand : {r_mcand[62:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == S_CALC);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed self-checking bench for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        finish_flag = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .funct3      (funct3),
        .op_a        (op_a),
        .op_b        (op_b),
        .finish_flag (finish_flag),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // poke: 0 none, 1 extra start during CALC, 2 finish_flag raised during CALC
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int poke);
        int busy_cnt;
        int lat;
        busy_cnt = 0;
        lat      = -1;
        @(negedge clock);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; funct3 = ~f; op_a = ~a; op_b = ~b;
        for (int j = 0; j < 40; j++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = j;
                break;
            end
            if (poke == 1 && j == 4) begin start = 1'b1; funct3 = 3'b011; end
            if (poke == 1 && j == 5) start = 1'b0;
            if (poke == 2 && j == 3) finish_flag = 1'b1;
            @(posedge clock); #1;
        end
        start = 1'b0;
        finish_flag = 1'b0;
        check({tag, ".busy_cycles"}, busy_cnt, exp_lat);
        check({tag, ".done_latency"}, lat, exp_lat);
        check({tag, ".result"}, result, exp_res);
        @(posedge clock); #1;
        check({tag, ".idle_after"}, {30'd0, busy, done}, 32'd0);
        check({tag, ".result_hold"}, result, exp_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;
        int busy_cnt;

        #12;
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.result", result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        do_op("mul_7x6",      3'b000, 32'd7,          32'd6,          32'd42,         32, 0);
        do_op("mulh_m1xm1",   3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  32, 0);
        do_op("mulhu_max",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32, 0);
        do_op("mulhsu_m1x2",  3'b010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  32, 0);
        do_op("mul_midstart", 3'b000, 32'h1234_5678,  32'h0000_0010,  32'h2345_6780,  32, 1);
        do_op("mulh_minsq",   3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32, 2);
        do_op("mul_m3x5",     3'b000, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  32, 0);
`ifdef MULDIV_DIV_EN
        do_op("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32, 0);
        do_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32, 0);
        do_op("divu_100_7",   3'b101, 32'd100,        32'd7,          32'd14,         32, 0);
        do_op("remu_100_7",   3'b111, 32'd100,        32'd7,          32'd2,          32, 0);
        do_op("div_big_3",    3'b100, 32'h8000_0001,  32'd3,          32'hD555_5556,  32, 0);
        do_op("rem_big_3",    3'b110, 32'h8000_0001,  32'd3,          32'hFFFF_FFFF,  32, 0);
        do_op("divu_by0",     3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  0,  0);
        do_op("rem_by0",      3'b110, 32'd5,          32'd0,          32'd5,          0,  0);
        do_op("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0,  0);
        do_op("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0,  0);
        do_op("divu_no_ovf",  3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32, 0);
`else
        do_op("div_10_2",     3'b100, 32'd10,         32'd2,          32'd0,          0,  0);
        do_op("divu_by0",     3'b101, 32'd10,         32'd0,          32'd0,          0,  0);
        do_op("remu_7_3",     3'b111, 32'd7,          32'd3,          32'd0,          0,  0);
`endif

        // start blocked while finish_flag is high
        @(negedge clock);
        finish_flag = 1'b1; start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3;
        @(posedge clock); #1;
        check("halt.busy", {31'd0, busy}, 32'd0);
        check("halt.done", {31'd0, done}, 32'd0);
        @(posedge clock); #1;
        check("halt.busy2", {31'd0, busy}, 32'd0);
        @(negedge clock);
        start = 1'b0; finish_flag = 1'b0;

        do_op("mul_again",    3'b000, 32'd7,          32'd6,          32'd42,         32, 0);

        // reset in the middle of CALC
        @(negedge clock);
        funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check("rst_mid.busy_before", {31'd0, busy}, 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid.busy", {31'd0, busy}, 32'd0);
        check("rst_mid.done", {31'd0, done}, 32'd0);
        check("rst_mid.result", result, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clock); #1;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        check("rst_mid.no_done", done_cnt, 32'd0);
        check("rst_mid.no_busy", busy_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
